// File: rtl/isdu_control_if.sv
// Control bundle between the SLC-3 sequencer and the datapath: status
// inputs to the sequencer plus every load, gate, mux-select, ALU-op and
// memory-strobe control the datapath consumes.
interface isdu_control_if;
  // datapath/user status into the sequencer
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       BEN;

  // register load enables
  logic       LD_MAR;
  logic       LD_MDR;
  logic       LD_IR;
  logic       LD_BEN;
  logic       LD_CC;
  logic       LD_REG;
  logic       LD_PC;
  logic       LD_LED;

  // bus drivers, one-hot or idle
  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic       GateMARMUX;

  // mux selects and ALU operation
  logic [1:0] PCMUX;
  logic       DRMUX;
  logic       SR1MUX;
  logic       SR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;

  // active-low memory strobes
  logic       Mem_OE;
  logic       Mem_WE;

  // sequencer side
  modport master (
    input  Run, Continue, Opcode, IR_5, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_OE, Mem_WE
  );

  // datapath side
  modport slave (
    output Run, Continue, Opcode, IR_5, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_OE, Mem_WE
  );
endinterface

// File: rtl/isdu_control.sv
// SLC-3 instruction sequencer. Moore FSM stepping fetch, decode and execute
// states; memory access states are stretched by a small wait counter so the
// access lasts MEM_WAIT+1 cycles. MEM_WAIT must lie in 0..7 (3-bit counter).
module isdu_control #(
  parameter int MEM_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  isdu_control_if.master bus
);

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_18, ST_33, ST_35, ST_32,
    ST_01, ST_05, ST_09,
    ST_00, ST_22,
    ST_12,
    ST_04, ST_21,
    ST_06, ST_25, ST_27,
    ST_07, ST_23, ST_16,
    ST_13, ST_P1, ST_P2
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(MEM_WAIT);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       cnt_last;

  assign cnt_last = (cnt_reg == CNT_LAST);

  // state and wait-counter registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_HALTED;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // next-state logic; the counter idles at 0 so every access starts from 0
  always_comb begin
    state_next = state_reg;
    cnt_next   = 3'd0;
    case (state_reg)
      ST_HALTED: if (bus.Run) state_next = ST_18;
      ST_18:     state_next = ST_33;
      ST_33: begin
        if (cnt_last) state_next = ST_35;
        else          cnt_next   = cnt_reg + 3'd1;
      end
      ST_35:     state_next = ST_32;
      ST_32: begin
        case (bus.Opcode)
          4'b0001: state_next = ST_01;
          4'b0101: state_next = ST_05;
          4'b1001: state_next = ST_09;
          4'b0000: state_next = ST_00;
          4'b1100: state_next = ST_12;
          4'b0100: state_next = ST_04;
          4'b0110: state_next = ST_06;
          4'b0111: state_next = ST_07;
          4'b1101: state_next = ST_13;
          default: state_next = ST_18;
        endcase
      end
      ST_01, ST_05, ST_09: state_next = ST_18;
      ST_00:     state_next = bus.BEN ? ST_22 : ST_18;
      ST_22:     state_next = ST_18;
      ST_12:     state_next = ST_18;
      ST_04:     state_next = ST_21;
      ST_21:     state_next = ST_18;
      ST_06:     state_next = ST_25;
      ST_07:     state_next = ST_23;
      ST_25: begin
        if (cnt_last) state_next = ST_27;
        else          cnt_next   = cnt_reg + 3'd1;
      end
      ST_27:     state_next = ST_18;
      ST_23:     state_next = ST_16;
      ST_16: begin
        if (cnt_last) state_next = ST_18;
        else          cnt_next   = cnt_reg + 3'd1;
      end
      ST_13:     state_next = ST_P1;
      ST_P1:     if (bus.Continue)  state_next = ST_P2;
      ST_P2:     if (!bus.Continue) state_next = ST_18;
      default:   state_next = ST_HALTED;
    endcase
  end

  // control decode from the current state (SR2MUX follows IR[5] in ALU ops)
  always_comb begin
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = 2'b00;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = 2'b00;
    bus.ALUK       = 2'b00;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    case (state_reg)
      ST_18: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.PCMUX  = 2'b00;
        bus.LD_PC  = 1'b1;
      end
      ST_33, ST_25: begin
        bus.Mem_OE = 1'b0;
        bus.LD_MDR = cnt_last;
      end
      ST_35: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
      end
      ST_32: bus.LD_BEN = 1'b1;
      ST_01, ST_05, ST_09: begin
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.DRMUX   = 1'b0;
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = bus.IR_5;
        if (state_reg == ST_05)      bus.ALUK = 2'b01;
        else if (state_reg == ST_09) bus.ALUK = 2'b10;
        else                         bus.ALUK = 2'b00;
      end
      ST_22: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = 2'b10;
        bus.ADDR1MUX = 1'b0;
        bus.ADDR2MUX = 2'b10;
      end
      ST_12: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = 2'b10;
        bus.ADDR1MUX = 1'b1;
        bus.ADDR2MUX = 2'b00;
        bus.SR1MUX   = 1'b1;
      end
      ST_04: begin
        bus.GatePC = 1'b1;
        bus.LD_REG = 1'b1;
        bus.DRMUX  = 1'b1;
      end
      ST_21: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = 2'b10;
        bus.ADDR1MUX = 1'b0;
        bus.ADDR2MUX = 2'b11;
      end
      ST_06, ST_07: begin
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = 2'b01;
        bus.SR1MUX     = 1'b1;
      end
      ST_27: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.DRMUX   = 1'b0;
      end
      ST_23: begin
        bus.GateALU = 1'b1;
        bus.ALUK    = 2'b11;
        bus.SR1MUX  = 1'b0;
        bus.LD_MDR  = 1'b1;
      end
      ST_16: bus.Mem_WE = 1'b0;
      ST_13: bus.LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/isdu_control.md
Name: isdu_control

Overview:
Moore-style instruction sequencer for the SLC-3 CPU. It sits directly upstream of the datapath and drives every load, gate, mux-select, ALU-op and memory-strobe signal the datapath consumes. It takes the opcode and condition bits back from the datapath and steps through the fetch, decode and execute states. It also supports Run/Continue handshakes for halt and PAUSE.

Parameters:
MEM_WAIT, 2, number of extra wait cycles per memory read or write (access state lasts MEM_WAIT+1 cycles; legal range 0..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; forces HALTED
Run  input  1  start execution from HALTED (level)
Continue  input  1  PAUSE release handshake (level)
Opcode  input  4  IR[15:12] from datapath
IR_5  input  1  IR[5], immediate select
BEN  input  1  branch-enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load enables
GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle
PCMUX  output  2  00 PC+1, 01 bus, 10 address adder
DRMUX  output  1  0 IR[11:9], 1 R7
SR1MUX  output  1  0 IR[11:9], 1 IR[8:6]
SR2MUX  output  1  0 register SR2, 1 sext(IR[4:0])
ADDR1MUX  output  1  0 PC, 1 SR1_OUT
ADDR2MUX  output  2  00 zero, 01 off6, 10 off9, 11 off11
ALUK  output  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
Mem_OE  output  1  active-low read strobe
Mem_WE  output  1  active-low write strobe

Behaviour:
- The state register updates on the clk rising edge. All outputs are a combinational decode of the current state only (Moore).
- Default output in every state: all controls 0, Mem_OE=1, Mem_WE=1. Each state asserts only the controls listed for it.
- reset=1 at any edge, including mid-access: next state HALTED, wait counter cleared. There is no partial write completion; Mem_WE deasserts the cycle after the edge.
- HALTED: idle. Run=1 moves to S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC. Next state S33.
- S33: Mem_OE=0 for MEM_WAIT+1 cycles; LD_MDR is high only on the last cycle. Next state S35.
- S35: GateMDR, LD_IR. Next state S32.
- S32: LD_BEN. Dispatch on Opcode:
  - 0001 ADD -> S01
  - 0101 AND -> S05
  - 1001 NOT -> S09
  - 0000 BR -> S00
  - 1100 JMP -> S12
  - 0100 JSR -> S04
  - 0110 LDR -> S06
  - 0111 STR -> S07
  - 1101 PAUSE -> S13
  - any other opcode -> S18 (treated as NOP)
- S01/S05/S09: GateALU, LD_REG, LD_CC, DRMUX=0, SR1MUX=1, SR2MUX=IR_5, ALUK=00/01/10 respectively. Next state S18.
- S00: BEN=1 -> S22, else -> S18.
- S22: LD_PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=10. Next state S18.
- S12: LD_PC, PCMUX=10, ADDR1MUX=1, ADDR2MUX=00, SR1MUX=1. Next state S18.
- S04: GatePC, LD_REG, DRMUX=1. Next state S21.
- S21: LD_PC, PCMUX=10, ADDR1MUX=0, ADDR2MUX=11. Next state S18.
- S06/S07: GateMARMUX, LD_MAR, ADDR1MUX=1, ADDR2MUX=01, SR1MUX=1. Next state S25 (LDR) or S23 (STR).
- S25: read identical to S33 (MEM_WAIT+1 cycles, LD_MDR on the last). Next state S27.
- S27: GateMDR, LD_REG, LD_CC, DRMUX=0. Next state S18.
- S23: GateALU, ALUK=11, SR1MUX=0, LD_MDR. Next state S16.
- S16: Mem_WE=0 for MEM_WAIT+1 cycles. Next state S18.
- S13: LD_LED for one cycle. Next state P1.
- P1: holds until Continue=1, then P2.
- P2: holds until Continue=0, then S18. A Continue already high on entry to P1 passes to P2 next cycle.
- Wait counter: 3 bits. Loaded to 0 on entry to S33/S25/S16 and increments each cycle in those states. The state exits when counter==MEM_WAIT.
- Run is ignored outside HALTED. Execution never returns to HALTED except via reset.

Test Plan:
- reset high 2 cycles, then low, Run=0 -> HALTED, Mem_OE=Mem_WE=1, all loads 0 for 10 cycles; Run=1 -> S18 next cycle (GatePC=LD_MAR=LD_PC=1).
- MEM_WAIT=2, Opcode=0001, IR_5=1 -> S18 1 cycle, Mem_OE=0 3 cycles with LD_MDR only on the 3rd, LD_IR 1 cycle, LD_BEN 1 cycle, then GateALU=LD_REG=LD_CC=1, SR2MUX=1, ALUK=00; fetch-to-execute 6 cycles.
- Opcode=0000, BEN=0 -> S00 then S18 with no LD_PC pulse; BEN=1 -> one cycle LD_PC=1, PCMUX=10, ADDR2MUX=10.
- Opcode=0111 -> MAR load (ADDR2MUX=01), LD_MDR with ALUK=11, then Mem_WE=0 for exactly 3 cycles, then S18.
- Opcode=1101 -> LD_LED pulse; Continue held 0 for 20 cycles keeps state; Continue=1 then 0 -> fetch resumes (GatePC=1) the cycle after Continue falls.
- reset asserted during 2nd cycle of S16 -> next cycle Mem_WE=1, HALTED; Run=1 -> clean fetch with wait counter restarted at 0.
